// File: rtl/fp_norm_seq_pkg.sv
// fp_pkg: shared floating-point types and constants for the sequential
// normaliser (fp_norm_seq) and its result packer (fp_pack).
//   state_t  : controller states IDLE / NORM / DONE
//   EXP_MAX  : all-ones biased exponent (infinity encoding)
//   MANT_W   : stored mantissa (fraction) width of single precision
//   BIAS     : single-precision exponent bias
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int         MANT_W  = 23;
  localparam int         BIAS    = 127;

endpackage

// File: rtl/fp_norm_seq_if.sv
// fp_norm_seq_if: operand / result handshake bundle of the normaliser.
//   in_valid/in_ready    : operand handshake
//   in_sign/in_exp       : sign and biased exponent of the raw sum
//   in_mant              : raw sum, bit MW+1 carry, bit MW hidden, MW-1:0 fraction
//   out_valid/out_ready  : result handshake
//   result               : packed {sign, exp[7:0], frac[MW-1:0]}
//   zero/overflow/underflow : status flags, valid with out_valid
// Modport master is the producer/consumer side, slave is the normaliser.
interface fp_norm_seq_if #(
  parameter int N  = 32,
  parameter int MW = 23
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [7:0]    in_exp;
  logic [MW+1:0] in_mant;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, result, zero, overflow, underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, result, zero, overflow, underflow
  );
endinterface

// File: rtl/fp_norm_seq_pack.sv
// fp_pack: combinational result packer.
//   sign, exp_val, frac : fields of a normal result
//   flush               : force signed zero {sign, 0, 0}
//   ovf                 : force signed infinity {sign, 8'hFF, 0} (wins over flush)
//   result              : packed N-bit word
module fp_pack
  import fp_pkg::*;
#(
  parameter int N  = 32,
  parameter int MW = MANT_W
) (
  input  logic          sign,
  input  logic [7:0]    exp_val,
  input  logic [MW-1:0] frac,
  input  logic          flush,
  input  logic          ovf,
  output logic [N-1:0]  result
);

  // Select infinity, signed zero or the normal encoding.
  always_comb begin
    if (ovf) begin
      result = {sign, EXP_MAX, {MW{1'b0}}};
    end else if (flush) begin
      result = {sign, 8'h00, {MW{1'b0}}};
    end else begin
      result = {sign, exp_val, frac};
    end
  end

endmodule

// File: rtl/fp_norm_seq.sv
// fp_norm_seq: sequential post-add normaliser. Accepts a raw sum (sign,
// exponent of the larger operand, carry+hidden+fraction mantissa), then
// normalises it one bit per cycle and presents a packed single-precision
// result with zero / overflow / underflow status.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fp_norm_seq_if.slave (operand and result handshakes)
// Denormals are not produced: any exponent reaching 0 flushes to signed zero.
module fp_norm_seq
  import fp_pkg::*;
#(
  parameter int N  = 32,
  parameter int MW = MANT_W
) (
  input  logic clk,
  input  logic rst,
  fp_norm_seq_if.slave bus
);

  state_t        state_r, state_nx;
  logic          sign_r;
  logic [7:0]    exp_r, exp_nx;
  logic [MW+1:0] mant_r, mant_nx;
  logic [N-1:0]  result_r;
  logic          zero_r, overflow_r, underflow_r;

  logic          load_s;
  logic          done_s;
  logic          flush_s;
  logic          ovf_s;
  logic          zero_s;
  logic          unf_s;
  logic [7:0]    exp_inc_s;
  logic [7:0]    pack_exp_s;
  logic [MW-1:0] pack_frac_s;
  logic [N-1:0]  pack_result_s;

  assign exp_inc_s = exp_r + 8'd1;

  // Next state, single-bit shift step and result selects.
  always_comb begin
    state_nx    = state_r;
    exp_nx      = exp_r;
    mant_nx     = mant_r;
    load_s      = 1'b0;
    done_s      = 1'b0;
    flush_s     = 1'b0;
    ovf_s       = 1'b0;
    zero_s      = 1'b0;
    unf_s       = 1'b0;
    pack_exp_s  = exp_r;
    pack_frac_s = mant_r[MW-1:0];
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          load_s   = 1'b1;
          state_nx = NORM;
        end else begin
          state_nx = IDLE;
        end
      end
      NORM: begin
        // Every branch but the left shift finishes this cycle.
        state_nx = DONE;
        done_s   = 1'b1;
        if (exp_r == EXP_MAX) begin
          ovf_s = 1'b1;
        end else if (mant_r == {(MW+2){1'b0}}) begin
          flush_s = 1'b1;
          zero_s  = 1'b1;
        end else if (mant_r[MW+1]) begin
          // Carry out: the right shift goes straight into the packed result.
          pack_exp_s  = exp_inc_s;
          pack_frac_s = mant_r[MW:1];
          if (exp_inc_s == EXP_MAX) begin
            ovf_s = 1'b1;
          end else begin
            ovf_s = 1'b0;
          end
        end else if (mant_r[MW]) begin
          if (exp_r == 8'h00) begin
            flush_s = 1'b1;
            unf_s   = 1'b1;
          end else begin
            flush_s = 1'b0;
          end
        end else if (exp_r <= 8'h01) begin
          // Another left shift would take the exponent to zero.
          flush_s = 1'b1;
          unf_s   = 1'b1;
        end else begin
          state_nx = NORM;
          done_s   = 1'b0;
          mant_nx  = {mant_r[MW:0], 1'b0};
          exp_nx   = exp_r - 8'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Operand capture, then the one-bit shift register and exponent counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r <= 1'b0;
      exp_r  <= 8'h00;
      mant_r <= {(MW+2){1'b0}};
    end else if (load_s) begin
      sign_r <= bus.in_sign;
      exp_r  <= bus.in_exp;
      mant_r <= bus.in_mant;
    end else begin
      exp_r  <= exp_nx;
      mant_r <= mant_nx;
    end
  end

  fp_pack #(
    .N  (N),
    .MW (MW)
  ) u_pack (
    .sign    (sign_r),
    .exp_val (pack_exp_s),
    .frac    (pack_frac_s),
    .flush   (flush_s),
    .ovf     (ovf_s),
    .result  (pack_result_s)
  );

  // Result and flags are latched once and held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r    <= {N{1'b0}};
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (done_s) begin
      result_r    <= pack_result_s;
      zero_r      <= zero_s;
      overflow_r  <= ovf_s;
      underflow_r <= unf_s;
    end else begin
      result_r    <= result_r;
      zero_r      <= zero_r;
      overflow_r  <= overflow_r;
      underflow_r <= underflow_r;
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

endmodule

// File: tb/tb_fp_norm_seq.sv
// tb_fp_norm_seq: scoreboard bench for fp_norm_seq. A driver issues directed
// and random operands and pushes the reference model's expectation; a
// monitor compares every cycle the DUT presents out_valid.
module tb_fp_norm_seq;

  typedef struct {
    logic [31:0] res;
    bit          z;
    bit          o;
    bit          u;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   hold_cnt = 0;
  bit   mon_en = 1'b1;
  exp_t sb[$];

  fp_norm_seq_if #(.N(32), .MW(23)) bus ();

  fp_norm_seq #(.N(32), .MW(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: closed-form normalisation. due holds the latency in edges.
  function automatic exp_t model(input bit s, input bit [7:0] e, input bit [24:0] m);
    exp_t x;
    int msb, lead, ne;
    bit [24:0] nm;
    x.z = 1'b0; x.o = 1'b0; x.u = 1'b0;
    x.res = {s, 31'd0};
    x.due = 1;
    if (e == 8'hFF) begin
      x.o = 1'b1;
      x.res = {s, 8'hFF, 23'd0};
    end else if (m == 25'd0) begin
      x.z = 1'b1;
    end else if (m[24]) begin
      ne = int'(e) + 1;
      if (ne == 255) begin
        x.o = 1'b1;
        x.res = {s, 8'hFF, 23'd0};
      end else begin
        x.res = {s, 8'(ne), m[23:1]};
      end
    end else begin
      msb = 0;
      for (int i = 0; i < 24; i++) if (m[i]) msb = i;
      lead = 23 - msb;
      if (lead == 0) begin
        if (e == 8'd0) x.u = 1'b1;
        else x.res = {s, e, m[22:0]};
      end else if (int'(e) - lead >= 1) begin
        nm = m << lead;
        x.res = {s, 8'(int'(e) - lead), nm[22:0]};
        x.due = lead + 1;
      end else begin
        x.u = 1'b1;
        x.due = ((e >= 8'd2) ? int'(e) - 1 : 0) + 1;
      end
    end
    return x;
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input bit z, input bit o, input bit u, input int lat);
    exp_t x;
    x.res = r; x.z = z; x.o = o; x.u = u; x.due = lat;
    return x;
  endfunction

  // Present an operand until accepted; queue the expectation at acceptance.
  task automatic send(input bit s, input bit [7:0] e, input bit [24:0] m, input exp_t x, input bit wait_neg);
    int g;
    g = 0;
    if (wait_neg) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    while (bus.in_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      total++; bad++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end else begin
      x.due = x.due + cyc + 1;
      sb.push_back(x);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  // Monitor: compares result/flags whenever out_valid is seen, drives out_ready.
  initial begin : monitor
    bit fresh;
    bit expect_low;
    fresh = 1'b1;
    expect_low = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        fresh = 1'b1;
        expect_low = 1'b0;
      end else if (expect_low) begin
        chk("valid_drop", 64'(bus.out_valid), 64'd0);
        expect_low = 1'b0;
      end else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_valid result=%h required=no_result", bus.result);
        end else begin
          chk("result", 64'(bus.result), 64'(sb[0].res));
          chk("flags", 64'({bus.zero, bus.overflow, bus.underflow}),
              64'({sb[0].z, sb[0].o, sb[0].u}));
          chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
          if (fresh) chk("latency", 64'(cyc), 64'(sb[0].due));
          fresh = 1'b0;
        end
      end
      if (hold_cnt > 0 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        hold_cnt--;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (mon_en && bus.out_valid && bus.out_ready && sb.size() != 0) begin
        void'(sb.pop_front());
        fresh = 1'b1;
        expect_low = 1'b1;
      end
    end
  end

  initial begin : driver
    bit s;
    bit [7:0] e;
    bit [24:0] m;
    int mode;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'h00;
    bus.in_mant  = 25'd0;

    // Reset state while rst is held.
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", 64'({bus.zero, bus.overflow, bus.underflow}), 64'd0);

    // Release reset and present the carry case on the very next edge.
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 8'h7F, 25'h1800000, mk(32'h40400000, 1'b0, 1'b0, 1'b0, 1), 1'b0);
    send(1'b0, 8'h80, 25'h0400000, mk(32'h3F800000, 1'b0, 1'b0, 1'b0, 2), 1'b1);
    send(1'b1, 8'h90, 25'h0000000, mk(32'h80000000, 1'b1, 1'b0, 1'b0, 1), 1'b1);
    send(1'b0, 8'hFE, 25'h1000000, mk(32'h7F800000, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    send(1'b0, 8'h02, 25'h0100000, mk(32'h00000000, 1'b0, 1'b0, 1'b1, 2), 1'b1);
    send(1'b1, 8'hFF, 25'h0C00000, mk(32'hFF800000, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    send(1'b1, 8'h00, 25'h0800001, mk(32'h80000000, 1'b0, 1'b0, 1'b1, 1), 1'b1);

    // Backpressure: result must hold for 5 stalled cycles.
    drain();
    hold_cnt = 5;
    send(1'b0, 8'h7F, 25'h1800000, mk(32'h40400000, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    drain();

    // Reset in the middle of a long left-shift sequence.
    send(1'b0, 8'h80, 25'h0000001, model(1'b0, 8'h80, 25'h0000001), 1'b1);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_flags", 64'({bus.zero, bus.overflow, bus.underflow}), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    send(1'b0, 8'h80, 25'h0400000, mk(32'h3F800000, 1'b0, 1'b0, 1'b0, 2), 1'b0);

    // Randomised operands against the reference model.
    for (int n = 0; n < 80; n++) begin
      s = 1'($urandom_range(0, 1));
      e = 8'($urandom_range(0, 254));
      m = 25'($urandom);
      mode = $urandom_range(0, 9);
      case (mode)
        0: e = 8'hFF;
        1: m = 25'd0;
        2: begin
          m[24] = 1'b1;
          if ($urandom_range(0, 3) == 0) e = 8'hFE;
        end
        3: begin
          m[24:23] = 2'b01;
          if ($urandom_range(0, 3) == 0) e = 8'h00;
        end
        default: begin
          m[24:23] = 2'b01;
          m = m >> $urandom_range(1, 23);
          if ($urandom_range(0, 1) == 0) e = 8'($urandom_range(0, 30));
        end
      endcase
      send(s, e, m, model(s, e, m), 1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
